data_memory_lsu: RTL and testbench

Parametrised, byte-addressable data memory for the MEM stage of the RISC-V pipeline core.
- Supports RV32I load/store widths (B/H/W, signed/unsigned loads) with byte-lane write masking.
- Uses a valid/ready request port and a fixed-latency, in-order response port.
- After reset, clears its contents through a hardware init sweep.
- Reports misaligned, out-of-range and illegal-funct3 accesses as faults instead of corrupting memory.

---
 rtl/data_memory_lsu.sv | 201 ++++++++++++++++++++
 tb/tb_data_memory_lsu.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/data_memory_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : data_memory_lsu
//  Purpose  : Byte-addressable RV32I data memory with valid/ready request
//             port, fixed-latency response pipe and post-reset init sweep.
//  Revision : 1.0
// ============================================================================
module data_memory_lsu #(
    parameter int          DEPTH_WORDS  = 1024,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] INIT_VALUE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        init_done
);

    localparam int c_addr_w = $clog2(DEPTH_WORDS);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_addr_w-1:0] r_init_cnt;

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rd_word;

    logic                w_accept;
    logic [c_addr_w-1:0] w_idx;
    logic                w_oor;
    logic                w_misalign;
    logic                w_bad_f3;
    logic                w_fault;
    logic                w_store;
    logic [3:0]          w_st_be;
    logic [31:0]         w_st_data;
    logic [3:0]          w_we;
    logic [c_addr_w-1:0] w_wr_idx;
    logic [31:0]         w_wr_data;

    logic        r_s1_valid;
    logic        r_s1_fault;
    logic        r_s1_load;
    logic [2:0]  r_s1_f3;
    logic [1:0]  r_s1_lane;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_fmt;
    logic [31:0] w_s1_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            req_ready  <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (r_init_cnt == c_addr_w'(DEPTH_WORDS - 1)) begin
                        r_state   <= ST_READY;
                        req_ready <= 1'b1;
                        init_done <= 1'b1;
                    end
                end
                ST_READY: begin
                    r_state <= ST_READY;
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    assign w_accept   = req_valid & req_ready;
    assign w_idx      = req_addr[c_addr_w+1:2];
    assign w_oor      = |req_addr[31:c_addr_w+2];
    assign w_misalign = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                        ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
    // Loads additionally allow the unsigned variants 100/101.
    assign w_bad_f3   = req_write ? (req_funct3 > 3'd2)
                                  : ((req_funct3 == 3'd3) | (req_funct3[2:1] == 2'b11));
    assign w_fault    = w_oor | w_misalign | w_bad_f3;
    assign w_store    = w_accept & req_write & ~w_fault;

    always_comb begin
        w_st_be   = 4'b0000;
        w_st_data = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                w_st_be   = 4'b0001 << req_addr[1:0];
                w_st_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_st_be   = req_addr[1] ? 4'b1100 : 4'b0011;
                w_st_data = {2{req_wdata[15:0]}};
            end
            2'b10:   w_st_be = 4'b1111;
            default: w_st_be = 4'b0000;
        endcase
    end

    // Single write port shared by the init sweep and committed stores.
    assign w_we      = (r_state == ST_INIT) ? 4'b1111 : (w_store ? w_st_be : 4'b0000);
    assign w_wr_idx  = (r_state == ST_INIT) ? r_init_cnt : w_idx;
    assign w_wr_data = (r_state == ST_INIT) ? INIT_VALUE : w_st_data;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_we[b]) begin
                r_mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
            end
        end
        if (w_accept) begin
            r_rd_word <= r_mem[w_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_fault <= 1'b0;
            r_s1_load  <= 1'b0;
            r_s1_f3    <= 3'b000;
            r_s1_lane  <= 2'b00;
        end else begin
            r_s1_valid <= w_accept;
            r_s1_fault <= w_accept & w_fault;
            r_s1_load  <= w_accept & ~req_write & ~w_fault;
            r_s1_f3    <= req_funct3;
            r_s1_lane  <= req_addr[1:0];
        end
    end

    assign w_byte = r_rd_word[8*r_s1_lane +: 8];
    assign w_half = r_s1_lane[1] ? r_rd_word[31:16] : r_rd_word[15:0];

    always_comb begin
        w_fmt = 32'h0000_0000;
        case (r_s1_f3)
            3'b000:  w_fmt = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_fmt = {{16{w_half[15]}}, w_half};
            3'b010:  w_fmt = r_rd_word;
            3'b100:  w_fmt = {24'h000000, w_byte};
            3'b101:  w_fmt = {16'h0000, w_half};
            default: w_fmt = 32'h0000_0000;
        endcase
    end

    assign w_s1_rdata = r_s1_load ? w_fmt : 32'h0000_0000;

    generate
        if (READ_LATENCY == 1) begin : g_direct
            assign rsp_valid = r_s1_valid;
            assign rsp_fault = r_s1_fault;
            assign rsp_rdata = w_s1_rdata;
        end else begin : g_pipe
            localparam int c_stages = READ_LATENCY - 1;
            logic [c_stages-1:0] r_pv;
            logic [c_stages-1:0] r_pf;
            logic [31:0]         r_pd [c_stages];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_pv <= '0;
                    r_pf <= '0;
                    for (int i = 0; i < c_stages; i++) begin
                        r_pd[i] <= 32'h0000_0000;
                    end
                end else begin
                    r_pv[0] <= r_s1_valid;
                    r_pf[0] <= r_s1_fault;
                    r_pd[0] <= w_s1_rdata;
                    for (int i = 1; i < c_stages; i++) begin
                        r_pv[i] <= r_pv[i-1];
                        r_pf[i] <= r_pf[i-1];
                        r_pd[i] <= r_pd[i-1];
                    end
                end
            end

            assign rsp_valid = r_pv[c_stages-1];
            assign rsp_fault = r_pf[c_stages-1];
            assign rsp_rdata = r_pd[c_stages-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_data_memory_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_memory_lsu
//  Purpose  : Directed self-checking bench for data_memory_lsu (two configs).
//  Revision : 1.0
// ============================================================================
module tb_data_memory_lsu;

    localparam int          DEPTH_A = 16;
    localparam int          LAT_A   = 1;
    localparam int          DEPTH_B = 32;
    localparam int          LAT_B   = 3;
    localparam logic [31:0] INIT_B  = 32'hCAFE_0000;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic clk = 1'b0;
    logic rst;

    logic        a_valid, a_write, a_ready, a_rv, a_rf, a_id;
    logic [2:0]  a_f3;
    logic [31:0] a_addr, a_wdata, a_rd;
    logic        b_valid, b_write, b_ready, b_rv, b_rf, b_id;
    logic [2:0]  b_f3;
    logic [31:0] b_addr, b_wdata, b_rd;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    data_memory_lsu #(.DEPTH_WORDS(DEPTH_A), .READ_LATENCY(LAT_A)) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
        .req_funct3(a_f3), .req_addr(a_addr), .req_wdata(a_wdata),
        .rsp_valid(a_rv), .rsp_rdata(a_rd), .rsp_fault(a_rf), .init_done(a_id)
    );

    data_memory_lsu #(.DEPTH_WORDS(DEPTH_B), .READ_LATENCY(LAT_B), .INIT_VALUE(INIT_B)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
        .req_funct3(b_f3), .req_addr(b_addr), .req_wdata(b_wdata),
        .rsp_valid(b_rv), .rsp_rdata(b_rd), .rsp_fault(b_rf), .init_done(b_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel_b, input logic v, input logic w, input logic [2:0] f3,
                         input logic [31:0] ad, input logic [31:0] wd);
        if (sel_b) begin
            b_valid = v; b_write = w; b_f3 = f3; b_addr = ad; b_wdata = wd;
        end else begin
            a_valid = v; a_write = w; a_f3 = f3; a_addr = ad; a_wdata = wd;
        end
    endtask

    // One request, then its response at the configured latency, then the pulse end.
    task automatic txn(input bit sel_b, input logic w, input logic [2:0] f3,
                       input logic [31:0] ad, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_f, input string tag);
        int lat;
        lat = sel_b ? LAT_B : LAT_A;
        drive(sel_b, 1'b1, w, f3, ad, wd);
        step();
        drive(sel_b, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        for (int i = 1; i < lat; i++) begin
            chk({tag, " early"}, 32'(sel_b ? b_rv : a_rv), 32'd0);
            step();
        end
        chk({tag, " valid"}, 32'(sel_b ? b_rv : a_rv), 32'd1);
        chk({tag, " rdata"}, sel_b ? b_rd : a_rd, exp_rd);
        chk({tag, " fault"}, 32'(sel_b ? b_rf : a_rf), 32'(exp_f));
        step();
        chk({tag, " pulse end"}, 32'(sel_b ? b_rv : a_rv), 32'd0);
    endtask

    initial begin
        bit flag;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #2;
        chk("rst a ready", 32'(a_ready), 32'd0);
        chk("rst a init_done", 32'(a_id), 32'd0);
        chk("rst a rsp_valid", 32'(a_rv), 32'd0);
        chk("rst a rsp_rdata", a_rd, 32'd0);
        chk("rst a rsp_fault", 32'(a_rf), 32'd0);
        chk("rst b ready", 32'(b_ready), 32'd0);
        chk("rst b rsp_valid", 32'(b_rv), 32'd0);
        step();
        step();

        // Release reset with an LW 0x3C already pending on A.
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b0, F_W, 32'h3C, 32'h0);
        flag = 1'b0;
        for (int i = 0; i < DEPTH_A - 1; i++) begin
            step();
            if (a_rv || a_ready || a_id) flag = 1'b1;
        end
        chk("init a activity before 16", 32'(flag), 32'd0);
        step();
        chk("init a ready at 16", 32'(a_ready), 32'd1);
        chk("init a done at 16", 32'(a_id), 32'd1);
        chk("init a no rsp yet", 32'(a_rv), 32'd0);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        chk("held LW 0x3C valid", 32'(a_rv), 32'd1);
        chk("held LW 0x3C rdata", a_rd, 32'h0000_0000);
        chk("held LW 0x3C fault", 32'(a_rf), 32'd0);
        step();
        chk("held LW pulse end", 32'(a_rv), 32'd0);

        txn(1'b0, 1'b1, F_W,  32'h10, 32'h1122_3344, 32'h0, 1'b0, "SW 0x10");
        txn(1'b0, 1'b1, F_B,  32'h11, 32'h0000_00AA, 32'h0, 1'b0, "SB 0x11");
        txn(1'b0, 1'b1, F_H,  32'h12, 32'h0000_BEEF, 32'h0, 1'b0, "SH 0x12");
        txn(1'b0, 1'b0, F_W,  32'h10, 32'h0, 32'hBEEF_AA44, 1'b0, "LW 0x10");
        txn(1'b0, 1'b0, F_B,  32'h11, 32'h0, 32'hFFFF_FFAA, 1'b0, "LB 0x11");
        txn(1'b0, 1'b0, F_BU, 32'h11, 32'h0, 32'h0000_00AA, 1'b0, "LBU 0x11");
        txn(1'b0, 1'b0, F_H,  32'h12, 32'h0, 32'hFFFF_BEEF, 1'b0, "LH 0x12");
        txn(1'b0, 1'b0, F_HU, 32'h12, 32'h0, 32'h0000_BEEF, 1'b0, "LHU 0x12");

        txn(1'b0, 1'b1, F_W,  32'h20, 32'h1234_5678, 32'h0, 1'b0, "SW 0x20");
        txn(1'b0, 1'b0, F_W,  32'h20, 32'h0, 32'h1234_5678, 1'b0, "LW 0x20 prior");
        txn(1'b0, 1'b0, F_H,  32'h13, 32'h0, 32'h0, 1'b1, "LH 0x13 misaligned");
        txn(1'b0, 1'b1, F_W,  32'h22, 32'hDEAD_BEEF, 32'h0, 1'b1, "SW 0x22 misaligned");
        txn(1'b0, 1'b0, F_W,  32'h40, 32'h0, 32'h0, 1'b1, "LW out of range");
        txn(1'b0, 1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1, "load f3 011");
        txn(1'b0, 1'b1, F_BU, 32'h20, 32'hFFFF_FFFF, 32'h0, 1'b1, "store f3 100");
        txn(1'b0, 1'b0, F_W,  32'h20, 32'h0, 32'h1234_5678, 1'b0, "LW 0x20 after faults");

        chk("b init_done", 32'(b_id), 32'd1);
        txn(1'b1, 1'b0, F_W, 32'h44, 32'h0, INIT_B, 1'b0, "B LW 0x44 init value");

        // Back-to-back store then load on the latency-3 instance.
        drive(1'b1, 1'b1, 1'b1, F_W, 32'h40, 32'hA5A5_A5A5);
        step();
        drive(1'b1, 1'b1, 1'b0, F_W, 32'h40, 32'h0);
        chk("pipe +1 no rsp", 32'(b_rv), 32'd0);
        step();
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        chk("pipe +2 no rsp", 32'(b_rv), 32'd0);
        step();
        chk("pipe SW rsp valid", 32'(b_rv), 32'd1);
        chk("pipe SW rsp rdata", b_rd, 32'd0);
        chk("pipe SW rsp fault", 32'(b_rf), 32'd0);
        step();
        chk("pipe LW rsp valid", 32'(b_rv), 32'd1);
        chk("pipe LW rsp rdata", b_rd, 32'hA5A5_A5A5);
        step();
        chk("pipe end", 32'(b_rv), 32'd0);

        // Two loads in flight when reset hits.
        drive(1'b1, 1'b1, 1'b0, F_W, 32'h40, 32'h0);
        step();
        step();
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        rst = 1'b1;
        #1;
        chk("mid rst rsp_valid", 32'(b_rv), 32'd0);
        chk("mid rst ready", 32'(b_ready), 32'd0);
        step();
        rst = 1'b0;
        flag = 1'b0;
        for (int i = 0; i < DEPTH_B - 1; i++) begin
            step();
            if (b_rv || b_ready || b_id) flag = 1'b1;
        end
        chk("reinit b activity before 32", 32'(flag), 32'd0);
        step();
        chk("reinit b ready at 32", 32'(b_ready), 32'd1);
        txn(1'b1, 1'b0, F_W, 32'h40, 32'h0, INIT_B, 1'b0, "B LW 0x40 after reinit");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
